// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier arbiter.
// Holds the controller state encoding, default parameter values and the
// round-robin slot helper used by the arbiter and the top level.
package booth_pkg;

  localparam int unsigned DEF_NREQ    = 4;
  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_TIMEOUT = 40;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Slot reached by stepping 'off' places from 'base' in a ring of 'n' slots.
  function automatic int unsigned rr_slot(input int unsigned base,
                                          input int unsigned off,
                                          input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/booth_mul_arbiter_if.sv
// Bus bundle between the requesters, the arbiter, the shared multiplier and
// the response consumer.
//   req_valid/req_a/req_b/req_ready    : request side, one lane per requester
//   mul_start/mul_m/mul_q              : issue to the multiplier
//   mul_done/mul_product               : completion from the multiplier
//   resp_valid/resp_ready/resp_id/
//   resp_product/resp_err              : tagged response
// slave  : arbiter view
// master : environment view (requesters, multiplier, consumer)
interface booth_mul_arbiter_if
  import booth_pkg::*;
#(
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned WIDTH = DEF_WIDTH
);

  localparam int unsigned IW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;

  logic                  mul_start;
  logic [WIDTH-1:0]      mul_m;
  logic [WIDTH-1:0]      mul_q;
  logic                  mul_done;
  logic [2*WIDTH-1:0]    mul_product;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [IW-1:0]         resp_id;
  logic [2*WIDTH-1:0]    resp_product;
  logic                  resp_err;

  modport slave (
    input  req_valid, req_a, req_b, mul_done, mul_product, resp_ready,
    output req_ready, mul_start, mul_m, mul_q,
           resp_valid, resp_id, resp_product, resp_err
  );

  modport master (
    output req_valid, req_a, req_b, mul_done, mul_product, resp_ready,
    input  req_ready, mul_start, mul_m, mul_q,
           resp_valid, resp_id, resp_product, resp_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req_valid : per-requester request
//   ptr       : highest-priority slot this round
//   grant     : one-hot winner (all zero when nothing is requested)
//   grant_idx : index of the winner
//   any_valid : at least one request present
module rr_arbiter
  import booth_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]         req_valid,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx,
  output logic                    any_valid
);

  localparam int unsigned IW = $clog2(NREQ);

  logic found;

  // Walk the ring starting at ptr; the first active slot wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req_valid[IW'(rr_slot(32'(ptr), i, NREQ))]) begin
        found = 1'b1;
        grant[IW'(rr_slot(32'(ptr), i, NREQ))] = 1'b1;
        grant_idx = IW'(rr_slot(32'(ptr), i, NREQ));
      end
    end
  end

  assign any_valid = |req_valid;

endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one sequential Booth multiplier between NREQ requesters.
// Picks a requester round-robin, latches its operands, pulses mul_start,
// waits for mul_done under a watchdog and returns the product (or an error)
// tagged with the requester index.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : request, multiplier and response signals (slave view)
// req_ready is combinational from req_valid and the round-robin pointer;
// every other output comes straight from a register.
module booth_mul_arbiter
  import booth_pkg::*;
#(
  parameter int unsigned NREQ    = DEF_NREQ,
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  booth_mul_arbiter_if.slave bus
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam int unsigned PW = 2 * WIDTH;

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc;
  logic             mul_start_q, mul_start_d;
  logic [WIDTH-1:0] op_m_q, op_m_d;
  logic [WIDTH-1:0] op_q_q, op_q_d;
  logic             resp_valid_q, resp_valid_d;
  logic [IW-1:0]    id_q, id_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic             err_q, err_d;

  logic [NREQ-1:0]  grant;
  logic [IW-1:0]    grant_idx;
  logic             any_valid;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_valid (bus.req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_valid (any_valid)
  );

  assign cnt_inc = cnt_q + CW'(1);

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      mul_start_q  <= 1'b0;
      op_m_q       <= '0;
      op_q_q       <= '0;
      resp_valid_q <= 1'b0;
      id_q         <= '0;
      prod_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      mul_start_q  <= mul_start_d;
      op_m_q       <= op_m_d;
      op_q_q       <= op_q_d;
      resp_valid_q <= resp_valid_d;
      id_q         <= id_d;
      prod_q       <= prod_d;
      err_q        <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    mul_start_d  = 1'b0;
    op_m_d       = op_m_q;
    op_q_d       = op_q_q;
    resp_valid_d = resp_valid_q;
    id_d         = id_q;
    prod_d       = prod_q;
    err_d        = err_q;

    case (state_q)
      ST_IDLE: begin
        // The winner always sees req_ready, so any request means a transfer.
        if (any_valid) begin
          op_m_d      = bus.req_a[grant_idx*WIDTH +: WIDTH];
          op_q_d      = bus.req_b[grant_idx*WIDTH +: WIDTH];
          id_d        = grant_idx;
          ptr_d       = IW'(rr_slot(32'(grant_idx), 1, NREQ));
          mul_start_d = 1'b1;
          state_d     = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // A done on the expiry cycle takes precedence over the watchdog.
        if (bus.mul_done) begin
          prod_d       = bus.mul_product;
          err_d        = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end else if (cnt_inc == CW'(TIMEOUT - 1)) begin
          prod_d       = '0;
          err_d        = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_RESP: begin
        if (resp_valid_q && bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Grants are only offered while idle and out of reset.
  assign bus.req_ready    = (state_q == ST_IDLE && !rst) ? grant : '0;
  assign bus.mul_start    = mul_start_q;
  assign bus.mul_m        = op_m_q;
  assign bus.mul_q        = op_q_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_id      = id_q;
  assign bus.resp_product = prod_q;
  assign bus.resp_err     = err_q;

endmodule
